uart_result_arbiter: RTL and testbench

- Shares the single UART transmit byte interface between the two hash cores of the dual-core design.
- Each core hands over a result word with a valid/ready handshake.
- The arbiter picks one core round-robin, frames the word as an ID byte plus data bytes (MSB first), and sequences them into the UART transmitter one byte at a time.
- A synchronized rewind input replays the last transmitted frame.

---
 rtl/uart_result_arbiter.sv | 118 +++++++++++
 tb/tb_uart_result_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_result_arbiter.sv
// uart_result_arbiter: round-robin framing of two cores' result words onto one UART byte port; FRAME_CHECKSUM_EN adds an XOR trailer byte
module uart_result_arbiter #(
  parameter int WORD_BYTES = 4,
  parameter logic [7:0] ID0 = 8'h41,
  parameter logic [7:0] ID1 = 8'h42
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req0_valid,
  input  logic [8*WORD_BYTES-1:0] req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [8*WORD_BYTES-1:0] req1_data,
  output logic                    req1_ready,
  input  logic                    rewind,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic                    grant,
  output logic                    frame_active,
  output logic [15:0]             frame_count
);
`ifdef FRAME_CHECKSUM_EN
  localparam int NB = WORD_BYTES + 2;
`else
  localparam int NB = WORD_BYTES + 1;
`endif
  localparam int IW = $clog2(NB);
  typedef enum logic [2:0] {IDLE, ARB, LOAD_REPLAY, SEND, GAP, WAIT} state_t;
  state_t state, nxt;
  logic last_grant, have_frame, rewind_pending, rewind_d, gnt_sel, take, last;
  logic [IW-1:0] byte_idx;
  logic [7:0] tx_hold, id;
  logic [7:0] fb [NB];
  logic [8*WORD_BYTES-1:0] word;
  assign gnt_sel = (req0_valid & req1_valid) ? !last_grant : req1_valid;
  assign take = (state == ARB) & (req0_valid | req1_valid);
  assign word = gnt_sel ? req1_data : req0_data;
  assign id = gnt_sel ? ID1 : ID0;
  assign last = byte_idx == IW'(NB - 1);
  assign tx_data = tx_start ? fb[byte_idx] : tx_hold;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0] chk;
  // XOR of ID and every data byte, stored alongside the frame so replays resend it
  always_comb begin
    chk = id;
    for (int i = 0; i < WORD_BYTES; i++) chk = chk ^ word[8*i +: 8];
  end
`endif
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  // next state plus the one-cycle ready/start strobes
  always_comb begin
    nxt = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    tx_start = 1'b0;
    case (state)
      IDLE: nxt = (rewind_pending & have_frame) ? LOAD_REPLAY : (req0_valid | req1_valid) ? ARB : IDLE;
      ARB: begin
        nxt = take ? SEND : IDLE;
        req0_ready = req0_valid & !gnt_sel;
        req1_ready = req1_valid & gnt_sel;
      end
      LOAD_REPLAY: nxt = SEND;
      SEND: begin
        tx_start = !tx_busy;
        nxt = tx_busy ? SEND : GAP;
      end
      GAP: nxt = WAIT;
      WAIT: nxt = tx_busy ? WAIT : last ? IDLE : SEND;
      default: nxt = IDLE;
    endcase
  end
  // frame bookkeeping, rewind edge capture and output registers
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      last_grant <= 1'b1;
      have_frame <= 1'b0;
      rewind_pending <= 1'b0;
      rewind_d <= 1'b0;
      byte_idx <= '0;
      grant <= 1'b0;
      frame_active <= 1'b0;
      frame_count <= '0;
      tx_hold <= '0;
    end else begin
      rewind_d <= rewind;
      rewind_pending <= (rewind & !rewind_d) | (rewind_pending & !(state == LOAD_REPLAY || (state == IDLE && !have_frame)));
      if (take) begin
        grant <= gnt_sel;
        last_grant <= gnt_sel;
        have_frame <= 1'b1;
      end
      if (take || state == LOAD_REPLAY) begin
        byte_idx <= '0;
        frame_active <= 1'b1;
      end
      if (tx_start) tx_hold <= fb[byte_idx];
      if (state == WAIT && !tx_busy) begin
        if (last) begin
          frame_count <= frame_count + 16'd1;
          frame_active <= 1'b0;
        end else byte_idx <= byte_idx + 1'b1;
      end
    end
  // frame buffer: byte 0 is the ID, then data MSB first
  always_ff @(posedge clock)
    if (take) begin
      fb[0] <= id;
      for (int i = 0; i < WORD_BYTES; i++) fb[i+1] <= word[8*(WORD_BYTES-1-i) +: 8];
`ifdef FRAME_CHECKSUM_EN
      fb[NB-1] <= chk;
`endif
    end
endmodule

// File: tb/tb_uart_result_arbiter.sv
// tb_uart_result_arbiter: directed scenarios checked against a frame-level byte-stream model
module tb_uart_result_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic req0_valid = 0, req1_valid = 0, rewind = 0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, tx_start, tx_busy, grant, frame_active;
  logic [7:0] tx_data;
  logic [15:0] frame_count;
  int checks = 0, errors = 0, busy_cnt = 0;
  logic [7:0] exp_bytes[$], last_frame[$];
  logic exp_gnt[$], exp_core[$];
  logic last_core, model_last = 1'b1, model_have = 1'b0;
  int model_count = 0;

  uart_result_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rewind(rewind), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant(grant), .frame_active(frame_active), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  // UART transmitter stand-in: busy for 10 cycles after each start
  always @(posedge clock or posedge reset)
    if (reset) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  assign tx_busy = busy_cnt != 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic pick(input logic v0, input logic v1);
    logic g;
    g = (v0 && v1) ? !model_last : v1;
    model_last = g;
    return g;
  endfunction

  task automatic queue_last();
    foreach (last_frame[i]) begin
      exp_bytes.push_back(last_frame[i]);
      exp_gnt.push_back(last_core);
    end
    model_count++;
  endtask

  task automatic push_frame(input logic c, input logic [31:0] d);
    logic [7:0] b, x;
    last_frame.delete();
    b = c ? 8'h42 : 8'h41;
    x = b;
    last_frame.push_back(b);
    for (int i = 3; i >= 0; i--) begin
      b = d[8*i +: 8];
      x = x ^ b;
      last_frame.push_back(b);
    end
`ifdef FRAME_CHECKSUM_EN
    last_frame.push_back(x);
`endif
    last_core = c;
    model_have = 1'b1;
    exp_core.push_back(c);
    queue_last();
  endtask

  task automatic push_replay();
    if (model_have) queue_last();
  endtask

  task automatic model_reset();
    exp_bytes.delete();
    exp_gnt.delete();
    exp_core.delete();
    model_last = 1'b1;
    model_have = 1'b0;
    model_count = 0;
  endtask

  // compare process: every transmitted byte, ready pulse and held tx_data against the model
  initial begin
    logic [7:0] last_tx;
    last_tx = 8'h00;
    forever begin
      @(negedge clock);
      if (reset) last_tx = 8'h00;
      else begin
        if (tx_start) begin
          check("start_in_frame", frame_active, 1'b1);
          if (exp_bytes.size() == 0) check("unexpected_tx_start", tx_data, 32'hFFFFFFFF);
          else begin
            check("tx_byte", tx_data, exp_bytes.pop_front());
            check("tx_grant", grant, exp_gnt.pop_front());
          end
          last_tx = tx_data;
        end else check("tx_hold", tx_data, last_tx);
        if (req0_ready || req1_ready) begin
          check("ready_onehot", req0_ready & req1_ready, 1'b0);
          if (exp_core.size() == 0) check("unexpected_ready", {req1_ready, req0_ready}, 2'b00);
          else check("ready_core", req1_ready, exp_core.pop_front());
        end
      end
    end
  end

  task automatic wait_ready(input logic c, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(c ? req1_ready : req0_ready) && n < budget);
    check("ready_timeout", c ? req1_ready : req0_ready, 1'b1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || frame_active || tx_busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", n < budget, 1'b1);
    repeat (20) @(negedge clock);
    check("frame_count", frame_count, model_count);
    check("idle_inactive", frame_active, 1'b0);
  endtask

  task automatic pulse_rewind();
    @(posedge clock); #1 rewind = 1'b1;
    @(posedge clock); #1 rewind = 1'b0;
  endtask

  initial begin
    logic [7:0] lit [5];
    int n, r;
    lit = '{8'h41, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    repeat (2) @(negedge clock);
    check("rst_ready", {req0_ready, req1_ready}, 2'b00);
    check("rst_tx", {tx_start, tx_data}, 9'h000);
    check("rst_grant_active", {grant, frame_active}, 2'b00);
    check("rst_count", frame_count, 16'h0);
    @(posedge clock); #1 reset = 1'b0;

    // rewind with nothing ever sent: ignored
    push_replay();
    pulse_rewind();
    drain(100);
    check("norewind_count", frame_count, 16'd0);

    // single word from core 0
    push_frame(pick(1'b1, 1'b0), 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) check("model_pin", exp_bytes[i], lit[i]);
    @(posedge clock); #1 req0_valid = 1'b1; req0_data = 32'hDEADBEEF;
    wait_ready(1'b0, 50);
    @(posedge clock); #1 req0_valid = 1'b0;
    drain(2000);
    check("s1_count", frame_count, 16'd1);
    check("s1_grant", grant, 1'b0);

    // both cores continuously valid: alternating grants
    for (int k = 0; k < 3; k++) begin
      r = pick(1'b1, 1'b1);
      push_frame(r[0], r[0] ? 32'h2 : 32'h1);
    end
    @(posedge clock); #1 req0_valid = 1'b1; req0_data = 32'h1; req1_valid = 1'b1; req1_data = 32'h2;
    n = 0;
    r = 0;
    while (r < 3 && n < 2000) begin
      @(negedge clock);
      n++;
      if (req0_ready || req1_ready) r++;
    end
    check("rr_timeout", r, 3);
    @(posedge clock); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    drain(2000);
    check("s2_count", frame_count, 16'd4);
    check("s2_grant", grant, 1'b1);

    // core 1 frame, then replay from IDLE
    push_frame(pick(1'b0, 1'b1), 32'h13579BDF);
    @(posedge clock); #1 req1_valid = 1'b1; req1_data = 32'h13579BDF;
    wait_ready(1'b1, 50);
    @(posedge clock); #1 req1_valid = 1'b0;
    drain(2000);
    push_replay();
    pulse_rewind();
    drain(2000);
    check("s3_count", frame_count, 16'd6);
    check("s3_grant", grant, 1'b1);

    // three rewind edges during a frame with core 0 waiting: one replay, then core 0
    push_frame(pick(1'b0, 1'b1), 32'hCAFEF00D);
    push_replay();
    push_frame(pick(1'b1, 1'b0), 32'h12345678);
    @(posedge clock); #1 req1_valid = 1'b1; req1_data = 32'hCAFEF00D;
    wait_ready(1'b1, 50);
    @(posedge clock); #1 req1_valid = 1'b0; req0_valid = 1'b1; req0_data = 32'h12345678;
    repeat (3) pulse_rewind();
    wait_ready(1'b0, 1000);
    @(posedge clock); #1 req0_valid = 1'b0;
    drain(2000);
    check("s4_count", frame_count, 16'd9);
    check("s4_grant", grant, 1'b0);

    // reset while the third byte launches
    push_frame(pick(1'b1, 1'b0), 32'h0BADC0DE);
    @(posedge clock); #1 req0_valid = 1'b1; req0_data = 32'h0BADC0DE;
    wait_ready(1'b0, 50);
    @(posedge clock); #1 req0_valid = 1'b0;
    n = 0;
    r = 0;
    while (r < 3 && n < 2000) begin
      @(negedge clock);
      n++;
      if (tx_start) r++;
    end
    check("s6_third_byte", r, 3);
    #1 reset = 1'b1;
    #1;
    check("s6_tx_start", tx_start, 1'b0);
    check("s6_active", frame_active, 1'b0);
    check("s6_count", frame_count, 16'd0);
    check("s6_tx_data", tx_data, 8'h00);
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    push_replay();
    pulse_rewind();
    drain(100);
    check("s6_post_count", frame_count, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
